// File: rtl/trx_path_sequencer.sv
// Time-shares the PostLNA receive/transmit path between one RX and one TX requester.
// An enable is held through a settle window before its grant; every release is followed by a guard gap.
module trx_path_sequencer #(
    parameter int CNT_W         = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int GUARD_CYCLES  = 2,
    parameter int MAX_BURST     = 64
) (
    input  logic Clock,
    input  logic ResetN,
    input  logic RxReq,
    input  logic TxReq,
    output logic RxGrant,
    output logic TxGrant,
    output logic RxEnable,
    output logic TxEnable,
    output logic Busy,
    output logic BurstCut
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RX_SETTLE = 3'd1,
        RX_ACTIVE = 3'd2,
        TX_SETTLE = 3'd3,
        TX_ACTIVE = 3'd4,
        GUARD     = 3'd5
    } state_t;

    // A zero-length guard still occupies one cycle so the enables never hand over edge-to-edge.
    localparam int              GUARD_LEN   = (GUARD_CYCLES == 0) ? 1 : GUARD_CYCLES;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD_LEN - 1);
    localparam logic [CNT_W-1:0] BURST_LAST  = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
    logic             last_tx_reg, last_tx_next;
    logic             burst_cut_reg, burst_cut_next;

    // On a tie the direction that did not own the path last time wins.
    function automatic state_t arbitrate(input logic rx, input logic tx, input logic last_tx);
        if (rx && tx)
            return last_tx ? RX_SETTLE : TX_SETTLE;
        else if (rx)
            return RX_SETTLE;
        else if (tx)
            return TX_SETTLE;
        else
            return IDLE;
    endfunction

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            last_tx_reg   <= 1'b1;
            burst_cut_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            last_tx_reg   <= last_tx_next;
            burst_cut_reg <= burst_cut_next;
        end
    end

    assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        last_tx_next   = last_tx_reg;
        burst_cut_next = 1'b0;
        case (state_reg)
            IDLE: begin
                state_next = arbitrate(RxReq, TxReq, last_tx_reg);
                cnt_next   = '0;
            end
            RX_SETTLE: begin
                if (!RxReq) begin
                    state_next = GUARD;
                    cnt_next   = '0;
                end else if (cnt_reg == SETTLE_LAST) begin
                    state_next = RX_ACTIVE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            RX_ACTIVE: begin
                if (!RxReq || cnt_reg == BURST_LAST) begin
                    state_next     = GUARD;
                    cnt_next       = '0;
                    last_tx_next   = 1'b0;
                    burst_cut_next = RxReq;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            TX_SETTLE: begin
                if (!TxReq) begin
                    state_next = GUARD;
                    cnt_next   = '0;
                end else if (cnt_reg == SETTLE_LAST) begin
                    state_next = TX_ACTIVE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            TX_ACTIVE: begin
                if (!TxReq || cnt_reg == BURST_LAST) begin
                    state_next     = GUARD;
                    cnt_next       = '0;
                    last_tx_next   = 1'b1;
                    burst_cut_next = TxReq;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            GUARD: begin
                if (cnt_reg == GUARD_LAST) begin
                    state_next = arbitrate(RxReq, TxReq, last_tx_reg);
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs decode the state directly so an asynchronous reset drops them without waiting for an edge.
    always_comb begin
        RxEnable = 1'b0;
        RxGrant  = 1'b0;
        TxEnable = 1'b0;
        TxGrant  = 1'b0;
        Busy     = (state_reg != IDLE);
        BurstCut = burst_cut_reg;
        case (state_reg)
            RX_SETTLE: RxEnable = 1'b1;
            RX_ACTIVE: begin
                RxEnable = 1'b1;
                RxGrant  = 1'b1;
            end
            TX_SETTLE: TxEnable = 1'b1;
            TX_ACTIVE: begin
                TxEnable = 1'b1;
                TxGrant  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trx_path_sequencer.sv
// Directed bench for trx_path_sequencer: one instance with default timing, one with a zero guard.
// Output vectors are {RxEnable, RxGrant, TxEnable, TxGrant, Busy, BurstCut}.
module tb_trx_path_sequencer;

    logic Clock;
    logic ResetN;
    logic rx_req0, tx_req0, rx_req1, tx_req1;
    logic rx_gr0, tx_gr0, rx_en0, tx_en0, busy0, cut0;
    logic rx_gr1, tx_gr1, rx_en1, tx_en1, busy1, cut1;

    int n_checks = 0;
    int n_fail   = 0;
    int inv_err  = 0;

    trx_path_sequencer #(
        .CNT_W(8), .SETTLE_CYCLES(4), .GUARD_CYCLES(2), .MAX_BURST(64)
    ) dut0 (
        .Clock(Clock), .ResetN(ResetN), .RxReq(rx_req0), .TxReq(tx_req0),
        .RxGrant(rx_gr0), .TxGrant(tx_gr0), .RxEnable(rx_en0), .TxEnable(tx_en0),
        .Busy(busy0), .BurstCut(cut0)
    );

    trx_path_sequencer #(
        .CNT_W(8), .SETTLE_CYCLES(4), .GUARD_CYCLES(0), .MAX_BURST(64)
    ) dut1 (
        .Clock(Clock), .ResetN(ResetN), .RxReq(rx_req1), .TxReq(tx_req1),
        .RxGrant(rx_gr1), .TxGrant(tx_gr1), .RxEnable(rx_en1), .TxEnable(tx_en1),
        .Busy(busy1), .BurstCut(cut1)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Enable exclusivity and grant-implies-enable, watched on every cycle of both instances.
    always @(negedge Clock) begin
        if ((rx_en0 && tx_en0) || (rx_gr0 && !rx_en0) || (tx_gr0 && !tx_en0) ||
            (rx_en1 && tx_en1) || (rx_gr1 && !rx_en1) || (tx_gr1 && !tx_en1))
            inv_err <= inv_err + 1;
    end

    task automatic tick;
        @(negedge Clock);
    endtask

    task automatic do_reset;
        ResetN = 1'b0;
        tick();
        ResetN = 1'b1;
    endtask

    task automatic test_reset;
        logic [5:0] obs;
        ResetN = 1'b1;
        rx_req0 = 1'b0; tx_req0 = 1'b0; rx_req1 = 1'b0; tx_req1 = 1'b0;
        #1 ResetN = 1'b0;
        #2;
        obs = {rx_en0, rx_gr0, tx_en0, tx_gr0, busy0, cut0};
        n_checks++;
        if (obs !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_dut0 obs=%b exp=%b", obs, 6'b000000);
        end
        obs = {rx_en1, rx_gr1, tx_en1, tx_gr1, busy1, cut1};
        n_checks++;
        if (obs !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_dut1 obs=%b exp=%b", obs, 6'b000000);
        end
        tick();
        ResetN = 1'b1;
        tick();
        obs = {rx_en0, rx_gr0, tx_en0, tx_gr0, busy0, cut0};
        n_checks++;
        if (obs !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_release_idle obs=%b exp=%b", obs, 6'b000000);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_rx;
        logic [5:0] obs, exp;
        rx_req0 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k <= 4)       exp = 6'b100010;
            else if (k <= 7)  exp = 6'b110010;
            else if (k <= 9)  exp = 6'b000010;
            else              exp = 6'b000000;
            obs = {rx_en0, rx_gr0, tx_en0, tx_gr0, busy0, cut0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL single_rx k=%0d obs=%b exp=%b", k, obs, exp);
            end
            if (k == 7) rx_req0 = 1'b0;
        end
        $display("test_single_rx done");
    endtask

    task automatic test_simultaneous;
        logic [5:0] obs, exp;
        do_reset();
        rx_req0 = 1'b1;
        tx_req0 = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k <= 4)        exp = 6'b100010;
            else if (k == 5)   exp = 6'b110010;
            else if (k <= 7)   exp = 6'b000010;
            else if (k <= 11)  exp = 6'b001010;
            else if (k == 12)  exp = 6'b001110;
            else if (k <= 14)  exp = 6'b000010;
            else               exp = 6'b000000;
            obs = {rx_en0, rx_gr0, tx_en0, tx_gr0, busy0, cut0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL simultaneous k=%0d obs=%b exp=%b", k, obs, exp);
            end
            if (k == 5)  rx_req0 = 1'b0;
            if (k == 12) tx_req0 = 1'b0;
        end
        n_checks++;
        if (inv_err !== 0) begin
            n_fail++;
            $display("FAIL invariant_simultaneous violations=%0d exp=0", inv_err);
        end
        $display("test_simultaneous done");
    endtask

    task automatic test_burst_cut;
        int grant_cnt = 0;
        int cut_cnt   = 0;
        int cut_k     = 0;
        int first_gr  = 0;
        logic [1:0] en;
        tx_req0 = 1'b1;
        for (int k = 1; k <= 75; k++) begin
            tick();
            if (tx_gr0) begin
                grant_cnt++;
                if (first_gr == 0) first_gr = k;
            end
            if (cut0) begin
                cut_cnt++;
                cut_k = k;
            end
            if (k == 71) begin
                en = {rx_en0, tx_en0};
                n_checks++;
                if (en !== 2'b10) begin
                    n_fail++;
                    $display("FAIL burst_fairness {rx_en,tx_en}=%b exp=%b", en, 2'b10);
                end
            end
            if (k == 10) rx_req0 = 1'b1;
        end
        n_checks++;
        if (grant_cnt !== 64) begin
            n_fail++;
            $display("FAIL burst_grant_len got=%0d exp=64", grant_cnt);
        end
        n_checks++;
        if (first_gr !== 5) begin
            n_fail++;
            $display("FAIL burst_grant_latency got=%0d exp=5", first_gr);
        end
        n_checks++;
        if (cut_cnt !== 1) begin
            n_fail++;
            $display("FAIL burst_cut_count got=%0d exp=1", cut_cnt);
        end
        n_checks++;
        if (cut_k !== 69) begin
            n_fail++;
            $display("FAIL burst_cut_cycle got=%0d exp=69", cut_k);
        end
        rx_req0 = 1'b0;
        tx_req0 = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_return_idle busy=%b exp=0", busy0);
        end
        $display("test_burst_cut done");
    endtask

    task automatic test_abort_settle;
        logic [5:0] obs, exp;
        rx_req0 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k <= 2)       exp = 6'b100010;
            else if (k <= 4)  exp = 6'b000010;
            else              exp = 6'b000000;
            obs = {rx_en0, rx_gr0, tx_en0, tx_gr0, busy0, cut0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL abort_settle k=%0d obs=%b exp=%b", k, obs, exp);
            end
            if (k == 2) rx_req0 = 1'b0;
        end
        $display("test_abort_settle done");
    endtask

    task automatic test_async_reset;
        logic [5:0] obs;
        tx_req0 = 1'b1;
        for (int k = 1; k <= 6; k++) tick();
        obs = {rx_en0, rx_gr0, tx_en0, tx_gr0, busy0, cut0};
        n_checks++;
        if (obs !== 6'b001110) begin
            n_fail++;
            $display("FAIL async_pre_active obs=%b exp=%b", obs, 6'b001110);
        end
        #2 ResetN = 1'b0;
        #1;
        obs = {rx_en0, rx_gr0, tx_en0, tx_gr0, busy0, cut0};
        n_checks++;
        if (obs !== 6'b000000) begin
            n_fail++;
            $display("FAIL async_drop obs=%b exp=%b", obs, 6'b000000);
        end
        tick();
        ResetN  = 1'b1;
        tx_req0 = 1'b0;
        tick();
        obs = {rx_en0, rx_gr0, tx_en0, tx_gr0, busy0, cut0};
        n_checks++;
        if (obs !== 6'b000000) begin
            n_fail++;
            $display("FAIL async_idle obs=%b exp=%b", obs, 6'b000000);
        end
        rx_req0 = 1'b1;
        tick();
        obs = {rx_en0, rx_gr0, tx_en0, tx_gr0, busy0, cut0};
        n_checks++;
        if (obs !== 6'b100010) begin
            n_fail++;
            $display("FAIL async_no_guard obs=%b exp=%b", obs, 6'b100010);
        end
        rx_req0 = 1'b0;
        tick(); tick(); tick();
        $display("test_async_reset done");
    endtask

    task automatic test_back_to_back;
        int last_tx_k = 0;
        int first_rx_k = 0;
        int off_cnt = 0;
        tx_req1 = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (tx_en1) last_tx_k = k;
            if (rx_en1 && first_rx_k == 0) first_rx_k = k;
            if (k <= 8 && !tx_en1 && !rx_en1) off_cnt++;
            if (k == 7) begin
                n_checks++;
                if (busy1 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_guard_busy busy=%b exp=1", busy1);
                end
            end
            if (k == 6) begin
                tx_req1 = 1'b0;
                rx_req1 = 1'b1;
            end
            if (k == 9) rx_req1 = 1'b0;
        end
        n_checks++;
        if (last_tx_k !== 6) begin
            n_fail++;
            $display("FAIL b2b_tx_fall got=%0d exp=6", last_tx_k);
        end
        n_checks++;
        if (first_rx_k !== 8) begin
            n_fail++;
            $display("FAIL b2b_rx_rise got=%0d exp=8", first_rx_k);
        end
        n_checks++;
        if (off_cnt !== 1) begin
            n_fail++;
            $display("FAIL b2b_off_cycles got=%0d exp=1", off_cnt);
        end
        n_checks++;
        if (busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_return_idle busy=%b exp=0", busy1);
        end
        n_checks++;
        if (inv_err !== 0) begin
            n_fail++;
            $display("FAIL invariant_overall violations=%0d exp=0", inv_err);
        end
        $display("test_back_to_back done");
    endtask

    initial begin
        test_reset();
        test_single_rx();
        test_simultaneous();
        test_burst_cut();
        test_abort_settle();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
